// File: rtl/nmu_eth_pkg.sv
// Ethernet header constants and the route-filter state type.
// Also holds the rule for how many beats cover one header.
package nmu_eth_pkg;

   localparam int DA_MAC_OFFSET = 0;
   localparam int ET_OFFSET     = 12;
   localparam int LAST_BYTE     = 13;
   localparam int ETH_HDR_BYTES = 14;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      FWD   = 2'd1,
      DRAIN = 2'd2,
      DROP  = 2'd3
   } filt_state_t;

   // Beats needed to see the whole 14-byte header at a given bus width.
   function automatic int calc_hold_beats(input int bus_width);
      int bytes_per_beat;
      bytes_per_beat = bus_width / 8;
      return (ETH_HDR_BYTES + bytes_per_beat - 1) / bytes_per_beat;
   endfunction

endpackage

// File: rtl/axis_hold_fifo.sv
// Small shift-register FIFO whose head entry is the registered output.
// It accepts a flush, and push and pop may happen together while full.
module axis_hold_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 3,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem     [DEPTH];
   logic [WIDTH-1:0] w_mem_nxt [DEPTH];
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_wr_idx;
   logic             w_push;
   logic             w_pop;

   assign o_full   = (r_count == CW'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign w_pop    = i_pop && !o_empty;
   assign w_push   = i_push && (!o_full || w_pop);
   assign w_wr_idx = w_pop ? (r_count - CW'(1)) : r_count;

   // Shift toward the head on pop, then drop the new word into the first free slot.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) w_mem_nxt[i] = r_mem[i];
      if (w_pop) begin
         for (int i = 0; i < DEPTH - 1; i++) w_mem_nxt[i] = r_mem[i + 1];
      end
      if (w_push) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == w_wr_idx) w_mem_nxt[i] = i_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_count <= '0;
      end else begin
         r_mem <= w_mem_nxt;
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      end
   end

   assign o_data  = r_mem[0];
   assign o_count = r_count;

endmodule

// File: rtl/mac_route_filter.sv
// Holds each packet's head until the parser verdict arrives.
// Then it forwards the packet with a latched route mask, or drops it and counts drops and runts.
module mac_route_filter
   import nmu_eth_pkg::*;
#(
   parameter  int AXIS_BUS_WIDTH  = 64,
   parameter  int AXIS_ID_WIDTH   = 4,
   parameter  int AXIS_DEST_WIDTH = 4,
   parameter  int HOLD_BEATS      = calc_hold_beats(AXIS_BUS_WIDTH),
   parameter  int CNT_WIDTH       = 32,
   localparam int NUM_AXIS_ID     = 2 ** AXIS_ID_WIDTH,
   localparam int DEST_W          = (AXIS_DEST_WIDTH < 1) ? 1 : AXIS_DEST_WIDTH,
   localparam int KEEP_W          = AXIS_BUS_WIDTH / 8
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
   input  logic [AXIS_ID_WIDTH-1:0]  axis_in_tid,
   input  logic [DEST_W-1:0]         axis_in_tdest,
   input  logic [KEEP_W-1:0]         axis_in_tkeep,
   input  logic                      axis_in_tlast,
   input  logic                      axis_in_tvalid,
   output logic                      axis_in_tready,
   input  logic [NUM_AXIS_ID-1:0]    route_mask_in,
   input  logic                      parsing_done_in,
   output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
   output logic [AXIS_ID_WIDTH-1:0]  axis_out_tid,
   output logic [DEST_W-1:0]         axis_out_tdest,
   output logic [KEEP_W-1:0]         axis_out_tkeep,
   output logic                      axis_out_tlast,
   output logic                      axis_out_tvalid,
   input  logic                      axis_out_tready,
   output logic [NUM_AXIS_ID-1:0]    axis_out_route_mask,
   output logic [CNT_WIDTH-1:0]      drop_count,
   output logic [CNT_WIDTH-1:0]      runt_count
);

   localparam int FIFO_W = AXIS_BUS_WIDTH + AXIS_ID_WIDTH + DEST_W + KEEP_W + 1;
   localparam int FIFO_D = HOLD_BEATS + 1;
   localparam int FCW    = $clog2(FIFO_D + 1);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   filt_state_t             r_state;
   filt_state_t             w_state_nxt;
   logic [NUM_AXIS_ID-1:0]  r_mask;
   logic [CNT_WIDTH-1:0]    r_drop_cnt;
   logic [CNT_WIDTH-1:0]    r_runt_cnt;

   logic [FIFO_W-1:0]       w_fifo_din;
   logic [FIFO_W-1:0]       w_fifo_dout;
   logic [FCW-1:0]          w_count;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_flush;
   logic                    w_latch;
   logic                    w_drop_inc;
   logic                    w_runt_inc;
   logic                    w_tready;
   logic                    w_out_vld;
   logic                    w_in_beat;

   // Handshake terms depend only on state and FIFO level, never on next-state logic.
   assign w_out_vld = ((r_state == FWD) || (r_state == DRAIN)) && !w_empty;
   assign w_pop     = w_out_vld && axis_out_tready;
   assign w_tready  = ((r_state == HOLD) && !w_full) ||
                      ((r_state == FWD)  && (!w_full || w_pop)) ||
                      (r_state == DROP);
   assign w_in_beat = axis_in_tvalid && w_tready;

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_flush     = 1'b0;
      w_latch     = 1'b0;
      w_drop_inc  = 1'b0;
      w_runt_inc  = 1'b0;
      case (r_state)
         HOLD: begin
            if (w_in_beat && parsing_done_in) begin
               w_latch = 1'b1;
               if (|route_mask_in) begin
                  w_push      = 1'b1;
                  w_state_nxt = axis_in_tlast ? DRAIN : FWD;
               end else begin
                  w_flush     = 1'b1;
                  w_drop_inc  = 1'b1;
                  w_state_nxt = axis_in_tlast ? HOLD : DROP;
               end
            end else if (w_in_beat && axis_in_tlast) begin
               w_flush    = 1'b1;
               w_runt_inc = 1'b1;
            end else if (w_count == FCW'(HOLD_BEATS)) begin
               // Header should have been parsed by now; discard the rest of the packet.
               w_flush     = 1'b1;
               w_runt_inc  = 1'b1;
               w_state_nxt = DROP;
            end else if (w_in_beat) begin
               w_push = 1'b1;
            end
         end
         FWD: begin
            w_push = w_in_beat;
            if (w_in_beat && axis_in_tlast) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (w_empty || (w_pop && (w_count == FCW'(1)))) w_state_nxt = HOLD;
         end
         DROP: begin
            if (w_in_beat && axis_in_tlast) w_state_nxt = HOLD;
         end
         default: w_state_nxt = HOLD;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) r_state <= HOLD;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_mask     <= '0;
         r_drop_cnt <= '0;
         r_runt_cnt <= '0;
      end else begin
         if (w_latch)    r_mask     <= route_mask_in;
         if (w_drop_inc) r_drop_cnt <= sat_inc(r_drop_cnt);
         if (w_runt_inc) r_runt_cnt <= sat_inc(r_runt_cnt);
      end
   end

   assign w_fifo_din = {axis_in_tdata, axis_in_tid, axis_in_tdest, axis_in_tkeep, axis_in_tlast};

   axis_hold_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_D)
   ) u_hold_fifo (
      .clk     (aclk),
      .rst     (areset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (w_fifo_din),
      .o_data  (w_fifo_dout),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign {axis_out_tdata, axis_out_tid, axis_out_tdest, axis_out_tkeep, axis_out_tlast} = w_fifo_dout;
   assign axis_out_tvalid     = w_out_vld;
   assign axis_in_tready      = w_tready;
   assign axis_out_route_mask = r_mask;
   assign drop_count          = r_drop_cnt;
   assign runt_count          = r_runt_cnt;

endmodule

// File: tb/tb_mac_route_filter.sv
// Bench for mac_route_filter: directed vector table, hand sequences, and random packets.
// Random packets are checked against a packet-level scoreboard and counter model.
module tb_mac_route_filter;

   localparam int BW  = 64;
   localparam int IDW = 4;
   localparam int DW  = 4;
   localparam int CW  = 4;
   localparam int HB  = 2;
   localparam int NID = 16;
   localparam int KW  = 8;
   localparam logic [CW-1:0] CMAX = '1;

   logic           aclk = 1'b0;
   logic           areset = 1'b1;
   logic [BW-1:0]  axis_in_tdata = '0;
   logic [IDW-1:0] axis_in_tid = '0;
   logic [DW-1:0]  axis_in_tdest = '0;
   logic [KW-1:0]  axis_in_tkeep = '0;
   logic           axis_in_tlast = 1'b0;
   logic           axis_in_tvalid = 1'b0;
   logic           axis_in_tready;
   logic [NID-1:0] route_mask_in = '0;
   logic           parsing_done_in = 1'b0;
   logic [BW-1:0]  axis_out_tdata;
   logic [IDW-1:0] axis_out_tid;
   logic [DW-1:0]  axis_out_tdest;
   logic [KW-1:0]  axis_out_tkeep;
   logic           axis_out_tlast;
   logic           axis_out_tvalid;
   logic           axis_out_tready = 1'b1;
   logic [NID-1:0] axis_out_route_mask;
   logic [CW-1:0]  drop_count;
   logic [CW-1:0]  runt_count;

   mac_route_filter #(
      .AXIS_BUS_WIDTH  (BW),
      .AXIS_ID_WIDTH   (IDW),
      .AXIS_DEST_WIDTH (DW),
      .CNT_WIDTH       (CW)
   ) dut (
      .aclk                (aclk),
      .areset              (areset),
      .axis_in_tdata       (axis_in_tdata),
      .axis_in_tid         (axis_in_tid),
      .axis_in_tdest       (axis_in_tdest),
      .axis_in_tkeep       (axis_in_tkeep),
      .axis_in_tlast       (axis_in_tlast),
      .axis_in_tvalid      (axis_in_tvalid),
      .axis_in_tready      (axis_in_tready),
      .route_mask_in       (route_mask_in),
      .parsing_done_in     (parsing_done_in),
      .axis_out_tdata      (axis_out_tdata),
      .axis_out_tid        (axis_out_tid),
      .axis_out_tdest      (axis_out_tdest),
      .axis_out_tkeep      (axis_out_tkeep),
      .axis_out_tlast      (axis_out_tlast),
      .axis_out_tvalid     (axis_out_tvalid),
      .axis_out_tready     (axis_out_tready),
      .axis_out_route_mask (axis_out_route_mask),
      .drop_count          (drop_count),
      .runt_count          (runt_count)
   );

   initial forever #5 aclk = ~aclk;

   typedef struct {
      logic [BW-1:0]  data;
      logic [IDW-1:0] tid;
      logic [DW-1:0]  dest;
      logic [KW-1:0]  keep;
      logic           last;
      logic [NID-1:0] mask;
   } beat_t;

   typedef struct {
      int             nbeats;
      int             done_idx;
      logic [NID-1:0] mask;
      int             exp_beats;
      int             exp_drop;
      int             exp_runt;
   } vec_t;

   beat_t exp_q[$];
   beat_t pk[8];
   int    n_chk = 0;
   int    n_fail = 0;
   int    n_out = 0;
   int    rdy_mode = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Output monitor: every transferred beat must match the head of the scoreboard.
   always @(negedge aclk) begin
      beat_t e;
      if (axis_out_tvalid === 1'b1 && axis_out_tready === 1'b1) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check("unexpected_out_beat", {48'd0, axis_out_route_mask}, 64'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("out_tdata", axis_out_tdata, e.data);
            check("out_tid",   64'(axis_out_tid), 64'(e.tid));
            check("out_tdest", 64'(axis_out_tdest), 64'(e.dest));
            check("out_tkeep", 64'(axis_out_tkeep), 64'(e.keep));
            check("out_tlast", 64'(axis_out_tlast), 64'(e.last));
            check("out_mask",  64'(axis_out_route_mask), 64'(e.mask));
         end
      end
   end

   initial begin
      forever begin
         @(posedge aclk);
         #1;
         case (rdy_mode)
            0:       axis_out_tready = 1'b1;
            1:       axis_out_tready = ~axis_out_tready;
            2:       axis_out_tready = ($urandom_range(0, 1) == 1);
            default: axis_out_tready = 1'b0;
         endcase
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic do_reset();
      areset = 1'b1;
      axis_in_tvalid = 1'b0;
      parsing_done_in = 1'b0;
      @(posedge aclk);
      @(posedge aclk);
      #1;
      areset = 1'b0;
      exp_q.delete();
   endtask

   task automatic build_pkt(input int n, input logic [NID-1:0] mask, input bit fwd);
      for (int i = 0; i < n; i++) begin
         pk[i].data = {$urandom, $urandom};
         pk[i].tid  = IDW'($urandom);
         pk[i].dest = DW'($urandom);
         pk[i].last = (i == n - 1);
         pk[i].keep = pk[i].last ? (8'hFF >> $urandom_range(0, 7)) : 8'hFF;
         pk[i].mask = mask;
         if (fwd) exp_q.push_back(pk[i]);
      end
   endtask

   // Called just after a rising edge; returns just after the edge that accepted the beat.
   task automatic drive_idx(input int i, input bit done);
      int guard;
      guard = 0;
      axis_in_tdata   = pk[i].data;
      axis_in_tid     = pk[i].tid;
      axis_in_tdest   = pk[i].dest;
      axis_in_tkeep   = pk[i].keep;
      axis_in_tlast   = pk[i].last;
      route_mask_in   = pk[i].mask;
      parsing_done_in = done;
      axis_in_tvalid  = 1'b1;
      @(negedge aclk);
      while (axis_in_tready !== 1'b1 && guard < 300) begin
         @(negedge aclk);
         guard++;
      end
      check("in_accept", 64'(axis_in_tready), 64'd1);
      @(posedge aclk);
      #1;
      axis_in_tvalid  = 1'b0;
      parsing_done_in = 1'b0;
   endtask

   task automatic send_pkt(input int n, input int done_idx, input logic [NID-1:0] mask,
                           input bit fwd, input int maxgap);
      build_pkt(n, mask, fwd);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, maxgap)) begin
            @(posedge aclk);
            #1;
         end
         drive_idx(i, (done_idx >= 0) && (i >= done_idx));
      end
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 1000) begin
         @(posedge aclk);
         #1;
         guard++;
      end
      repeat (3) begin
         @(posedge aclk);
         #1;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   vec_t vec[7];
   int   base;
   int   exp_drop;
   int   exp_runt;
   int   exp_beats_total;

   initial begin
      vec[0] = '{3, 1,  16'h0002, 3, 0, 0};
      vec[1] = '{3, 1,  16'h0000, 0, 1, 0};
      vec[2] = '{1, -1, 16'h0001, 0, 0, 1};
      vec[3] = '{2, 0,  16'h0001, 2, 0, 0};
      vec[4] = '{1, 0,  16'h0008, 1, 0, 0};
      vec[5] = '{1, 0,  16'h0000, 0, 1, 0};
      vec[6] = '{4, -1, 16'h0004, 0, 0, 1};

      // Reset values
      do_reset();
      check("rst_out_tvalid", 64'(axis_out_tvalid), 64'd0);
      check("rst_out_tdata",  axis_out_tdata, 64'd0);
      check("rst_out_tid",    64'(axis_out_tid), 64'd0);
      check("rst_out_tdest",  64'(axis_out_tdest), 64'd0);
      check("rst_out_tkeep",  64'(axis_out_tkeep), 64'd0);
      check("rst_out_tlast",  64'(axis_out_tlast), 64'd0);
      check("rst_out_mask",   64'(axis_out_route_mask), 64'd0);
      check("rst_drop",       64'(drop_count), 64'd0);
      check("rst_runt",       64'(runt_count), 64'd0);
      check("rst_in_tready",  64'(axis_in_tready), 64'd1);

      // Directed vector table
      for (int k = 0; k < 7; k++) begin
         do_reset();
         rdy_mode = 0;
         base = n_out;
         send_pkt(vec[k].nbeats, vec[k].done_idx, vec[k].mask, vec[k].exp_beats != 0, 0);
         wait_drain();
         check($sformatf("vec%0d_beats", k), 64'(n_out - base), 64'(vec[k].exp_beats));
         check($sformatf("vec%0d_drop", k),  64'(drop_count), 64'(vec[k].exp_drop));
         check($sformatf("vec%0d_runt", k),  64'(runt_count), 64'(vec[k].exp_runt));
      end

      // First output beat appears the cycle after the verdict beat
      do_reset();
      rdy_mode = 0;
      base = n_out;
      build_pkt(3, 16'h0002, 1'b1);
      drive_idx(0, 1'b0);
      check("lat_pre_verdict_tvalid", 64'(axis_out_tvalid), 64'd0);
      drive_idx(1, 1'b1);
      check("lat_post_verdict_tvalid", 64'(axis_out_tvalid), 64'd1);
      check("lat_post_verdict_mask", 64'(axis_out_route_mask), 64'h2);
      drive_idx(2, 1'b1);
      wait_drain();
      check("lat_beats", 64'(n_out - base), 64'd3);
      check("lat_drop", 64'(drop_count), 64'd0);
      check("lat_runt", 64'(runt_count), 64'd0);

      // Dropped packet followed by a forwarded one
      do_reset();
      base = n_out;
      send_pkt(3, 1, 16'h0000, 1'b0, 0);
      send_pkt(3, 1, 16'h0001, 1'b1, 0);
      wait_drain();
      check("dropfwd_beats", 64'(n_out - base), 64'd3);
      check("dropfwd_drop", 64'(drop_count), 64'd1);
      check("dropfwd_runt", 64'(runt_count), 64'd0);

      // One-beat runt: input ready again right after
      do_reset();
      base = n_out;
      send_pkt(1, -1, 16'h0000, 1'b0, 0);
      check("runt_tready_next", 64'(axis_in_tready), 64'd1);
      wait_drain();
      check("runt_count", 64'(runt_count), 64'd1);
      check("runt_beats", 64'(n_out - base), 64'd0);

      // Back-to-back packets with toggling downstream ready
      do_reset();
      rdy_mode = 1;
      base = n_out;
      send_pkt(3, 1, 16'h0004, 1'b1, 0);
      @(negedge aclk);
      check("drain_tready_low", 64'(axis_in_tready), 64'd0);
      @(posedge aclk);
      #1;
      send_pkt(3, 1, 16'h0008, 1'b1, 0);
      wait_drain();
      check("b2b_beats", 64'(n_out - base), 64'd6);

      // Reset in the middle of a 5-beat packet
      do_reset();
      rdy_mode = 3;
      base = n_out;
      build_pkt(5, 16'h0002, 1'b0);
      drive_idx(0, 1'b0);
      drive_idx(1, 1'b1);
      areset = 1'b1;
      @(posedge aclk);
      #1;
      areset = 1'b0;
      check("mid_rst_tvalid", 64'(axis_out_tvalid), 64'd0);
      check("mid_rst_tdata",  axis_out_tdata, 64'd0);
      check("mid_rst_mask",   64'(axis_out_route_mask), 64'd0);
      check("mid_rst_tready", 64'(axis_in_tready), 64'd1);
      rdy_mode = 0;
      drive_idx(2, 1'b0);
      drive_idx(3, 1'b0);
      drive_idx(4, 1'b0);
      wait_drain();
      check("mid_rst_beats", 64'(n_out - base), 64'd0);
      check("mid_rst_runt", 64'(runt_count), 64'd1);
      check("mid_rst_drop", 64'(drop_count), 64'd0);

      // Drop counter saturation
      do_reset();
      for (int k = 1; k <= 17; k++) begin
         send_pkt(1, 0, 16'h0000, 1'b0, 0);
         repeat (2) begin
            @(posedge aclk);
            #1;
         end
         check($sformatf("sat_drop_%0d", k), 64'(drop_count), (k >= 15) ? 64'(CMAX) : 64'(k));
      end

      // Random packets against the packet-level model
      do_reset();
      rdy_mode = 2;
      base = n_out;
      exp_drop = 0;
      exp_runt = 0;
      exp_beats_total = 0;
      for (int p = 0; p < 40; p++) begin
         int             n;
         int             d;
         logic [NID-1:0] m;
         bit             fwd;
         n = $urandom_range(1, 5);
         if ($urandom_range(0, 3) == 0) d = -1;
         else d = $urandom_range(0, ((n < HB) ? n : HB) - 1);
         if ($urandom_range(0, 3) == 0) m = '0;
         else m = NID'($urandom) | (NID'(1) << $urandom_range(0, NID - 1));
         fwd = (d >= 0) && (m != '0);
         if (d < 0)       exp_runt = (exp_runt >= 15) ? 15 : exp_runt + 1;
         else if (m == 0) exp_drop = (exp_drop >= 15) ? 15 : exp_drop + 1;
         if (fwd) exp_beats_total += n;
         send_pkt(n, d, m, fwd, 2);
      end
      wait_drain();
      check("rand_beats", 64'(n_out - base), 64'(exp_beats_total));
      check("rand_drop", 64'(drop_count), 64'(exp_drop));
      check("rand_runt", 64'(runt_count), 64'(exp_runt));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
